dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single atomic/data-memory request port among N core-side data requesters (D-cache or uncached paths).
- Captures one-cycle strobes into per-requester pending bits and grants round-robin.
- Drives one transaction at a time into the atomic unit port: one-hot core ID, registered request fields, one-cycle strobe.
- Returns a one-cycle done and the read data to the granted requester only.

Parameters:
- N, 2, number of requesters; one-hot ID width; supported range 1..2.
- XLEN, 32, address width.
- CLSIZE, 256, cache-line data width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_strobe_i  in  N  per-requester one-cycle request pulse
- req_addr_i  in  N*XLEN  requester k uses bits [k*XLEN +: XLEN]
- req_rw_i  in  N  1 = write
- req_data_i  in  N*CLSIZE  write line, slice k
- req_is_amo_i  in  N  atomic request flag
- req_amo_type_i  in  N*5  AMO funct5, slice k
- req_done_o  out  N  one-cycle completion, one-hot
- req_data_o  out  CLSIZE  read data, valid when any req_done_o bit is high
- core_id_o  out  N  one-hot grant ID to the atomic unit
- core_strobe_o  out  1  one-cycle request strobe to the atomic unit
- core_addr_o  out  XLEN  registered address
- core_rw_o  out  1  registered rw
- core_data_o  out  CLSIZE  registered write data
- core_is_amo_o  out  1  registered AMO flag
- core_amo_type_o  out  5  registered AMO type
- core_done_i  in  1  completion from the atomic unit
- core_data_i  in  CLSIZE  read data from the atomic unit

Behaviour:
- Clocking and reset: all state on the rising edge of clk_i; reset synchronous, active-high.
- Reset values:
  - state = IDLE; pending = 0; rr_ptr = 0.
  - req_done_o = 0, req_data_o = 0, core_strobe_o = 0.
  - core_id_o = 1 (requester 0).
  - core_addr_o, core_rw_o, core_data_o, core_is_amo_o and core_amo_type_o = 0.
- Requester contract:
  - Each requester holds its addr, rw, data, is_amo and amo_type stable from its strobe until its req_done_o.
  - It issues no new strobe before its done.
- Pending register:
  - pending[k] sets the cycle after req_strobe_i[k].
  - It clears in the RESP cycle for the granted k.
  - If set and clear hit the same bit in the same cycle, set wins.
  - A strobe while pending[k] is already 1 is ignored.
- Winner selection: first set bit of pending, searched circularly starting at rr_ptr.
- FSM states and transitions:
  - IDLE: if pending != 0, select the winner and latch its fields into the core_* outputs, with core_id_o = one-hot(winner); go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: core_strobe_o = 1 for exactly this cycle. If core_done_i = 1, latch core_data_i and go to RESP; otherwise go to WAIT.
  - WAIT: core_strobe_o = 0. On core_done_i, latch core_data_i into the response register and go to RESP.
  - RESP: req_done_o[grant] = 1 and req_data_o = latched data. Clear pending[grant], set rr_ptr = (grant+1) mod N, go to IDLE.
- Output holding:
  - core_id_o and all core_* fields stay stable from ISSUE through RESP, and remain at the last grant while IDLE. The atomic unit decodes AMO type and reservations combinationally, so this stability is required.
  - An AMO's read and write phases stay inside a single grant, so no other requester can interleave.
- Latency:
  - Strobe at cycle t gives core_strobe_o at t+2 if the arbiter is idle.
  - req_done_o arrives one cycle after core_done_i.
  - Back-to-back grants have 1 IDLE cycle between RESP and the next ISSUE.
- Other cases:
  - core_done_i outside ISSUE/WAIT is ignored.
  - req_data_o keeps its last value outside RESP.
  - Reset mid-transaction aborts everything to reset values. Any in-flight downstream operation is discarded, and the downstream is reset by the same rst_i.
  - N = 1: arbitration degenerates; rr_ptr is constant 0.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index set pending bit, and rr_ptr is neither used nor updated.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
1. Single read: req0 strobe, addr 0x0000_1040, rw = 0. Expect core_strobe_o 2 cycles later with core_id_o = 01 and addr 0x0000_1040. core_done_i with data 0xAB..AB returns req_done_o = 01 and req_data_o = 0xAB..AB one cycle later.
2. Simultaneous strobes from req0 and req1 after reset: req0 is granted first, req1 second (core_id_o 01 then 10). A second simultaneous pair is then granted req0 then req1 again, because rr_ptr has wrapped back to 0 after req1's grant. With DMEM_ARB_FIXED_PRIO_EN defined, req0 always wins first.
3. AMO hold: req1 amoadd (is_amo = 1, type 00000, addr 0x2000) with req0 strobing during WAIT. core_id_o stays 10 and core_addr_o stays 0x2000 until req1's done. req0 is granted only after that.
4. Zero-wait done: core_done_i asserted in the ISSUE cycle. FSM goes directly to RESP, req_done_o pulses for exactly one cycle, and no WAIT cycle occurs.
5. Reset during WAIT: rst_i asserted for 1 cycle. All outputs return to reset values (core_id_o = 01, strobe 0, done 0), pending = 0, and no stale done is delivered afterwards.
6. Duplicate strobe: req0 strobes twice before its done. Exactly one downstream transaction and one req_done_o pulse are produced.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the atomic/data-memory port among N requesters, one transaction at a time.
// Build option DMEM_ARB_FIXED_PRIO_EN: the lowest-index pending requester always wins (no round-robin).

module dmem_arb_pend (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  input  logic clr_i,
  output logic pend_o
);
  // A strobe landing in the same cycle as the clear keeps the bit set.
  always_ff @(posedge clk_i)
    if (rst_i) pend_o <= 1'b0;
    else       pend_o <= strobe_i | (pend_o & ~clr_i);
endmodule

module dmem_arbiter #(
  parameter int N      = 2,
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          req_strobe_i,
  input  logic [N*XLEN-1:0]     req_addr_i,
  input  logic [N-1:0]          req_rw_i,
  input  logic [N*CLSIZE-1:0]   req_data_i,
  input  logic [N-1:0]          req_is_amo_i,
  input  logic [N*5-1:0]        req_amo_type_i,
  output logic [N-1:0]          req_done_o,
  output logic [CLSIZE-1:0]     req_data_o,
  output logic [N-1:0]          core_id_o,
  output logic                  core_strobe_o,
  output logic [XLEN-1:0]       core_addr_o,
  output logic                  core_rw_o,
  output logic [CLSIZE-1:0]     core_data_o,
  output logic                  core_is_amo_o,
  output logic [4:0]            core_amo_type_o,
  input  logic                  core_done_i,
  input  logic [CLSIZE-1:0]     core_data_i
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;

  logic [N-1:0]             pending, pend_clr, lo_mask, hi_pend, scan_hi, scan_all;
  logic [PW-1:0]            rr_ptr, grant, winner, hi_idx, all_idx;
  logic                     hi_vld, all_vld;
  logic [CLSIZE-1:0]        resp_q;

  logic [N-1:0][XLEN-1:0]   addr_a;
  logic [N-1:0][CLSIZE-1:0] data_a;
  logic [N-1:0][4:0]        type_a;

  assign addr_a = req_addr_i;
  assign data_a = req_data_i;
  assign type_a = req_amo_type_i;

  for (genvar k = 0; k < N; k++) begin : g_lane
    dmem_arb_pend u_pend (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .strobe_i (req_strobe_i[k]),
      .clr_i    (pend_clr[k]),
      .pend_o   (pending[k])
    );
  end

  // Circular search: lowest set bit at or above rr_ptr, else wrap to lowest set bit overall.
  assign lo_mask = (N'(1) << rr_ptr) - N'(1);
  assign hi_pend = pending & ~lo_mask;

  always_comb begin
    scan_hi  = hi_pend;
    scan_all = pending;
    hi_vld   = 1'b0;
    all_vld  = 1'b0;
    hi_idx   = '0;
    all_idx  = '0;
    for (int k = 0; k < N; k++) begin
      if (!hi_vld && scan_hi[0]) begin
        hi_vld = 1'b1;
        hi_idx = PW'(k);
      end
      if (!all_vld && scan_all[0]) begin
        all_vld = 1'b1;
        all_idx = PW'(k);
      end
      scan_hi  = scan_hi >> 1;
      scan_all = scan_all >> 1;
    end
    winner = hi_vld ? hi_idx : all_idx;
  end

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk_i)
    if (rst_i)              rr_ptr <= '0;
    else if (state == RESP) rr_ptr <= (int'(grant) == N-1) ? '0 : grant + PW'(1);
`endif

  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx      = state;
    core_strobe_o = 1'b0;
    req_done_o    = '0;
    pend_clr      = '0;
    unique case (state)
      IDLE:  if (|pending) state_nx = ISSUE;
      ISSUE: begin
        core_strobe_o = 1'b1;
        state_nx      = core_done_i ? RESP : WAIT;
      end
      WAIT:  if (core_done_i) state_nx = RESP;
      RESP: begin
        req_done_o = core_id_o;
        pend_clr   = core_id_o;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured once per grant and held so the atomic unit sees stable decode inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant           <= '0;
      core_id_o       <= N'(1);
      core_addr_o     <= '0;
      core_rw_o       <= 1'b0;
      core_data_o     <= '0;
      core_is_amo_o   <= 1'b0;
      core_amo_type_o <= '0;
      resp_q          <= '0;
    end else begin
      if (state == IDLE && |pending) begin
        grant           <= winner;
        core_id_o       <= N'(1) << winner;
        core_addr_o     <= addr_a[winner];
        core_rw_o       <= req_rw_i[winner];
        core_data_o     <= data_a[winner];
        core_is_amo_o   <= req_is_amo_i[winner];
        core_amo_type_o <= type_a[winner];
      end
      if ((state == ISSUE || state == WAIT) && core_done_i)
        resp_q <= core_data_i;
    end
  end

  assign req_data_o = resp_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic against a timestamp-based reference model.
module tb_dmem_arbiter;
  localparam int N = 2, XLEN = 32, CLSIZE = 256;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]             strb;
  logic [N-1:0][XLEN-1:0]   r_addr;
  logic [N-1:0]             r_rw, r_amo;
  logic [N-1:0][CLSIZE-1:0] r_data;
  logic [N-1:0][4:0]        r_type;
  logic [N-1:0]             req_done, core_id;
  logic [CLSIZE-1:0]        req_data, core_data, cdata;
  logic                     core_strobe, core_rw, core_is_amo, cdone;
  logic [XLEN-1:0]          core_addr;
  logic [4:0]               core_amo_type;

  always #5 clk = ~clk;

  dmem_arbiter #(.N(N), .XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_strobe_i(strb), .req_addr_i(r_addr), .req_rw_i(r_rw), .req_data_i(r_data),
    .req_is_amo_i(r_amo), .req_amo_type_i(r_type),
    .req_done_o(req_done), .req_data_o(req_data),
    .core_id_o(core_id), .core_strobe_o(core_strobe), .core_addr_o(core_addr),
    .core_rw_o(core_rw), .core_data_o(core_data), .core_is_amo_o(core_is_amo),
    .core_amo_type_o(core_amo_type), .core_done_i(cdone), .core_data_i(cdata)
  );

  // reference model: pending set, rotating pointer, and timestamps of the current grant
  logic [N-1:0]      m_pend, outst;
  logic [IW-1:0]     m_rr, m_gnt;
  bit                m_busy;
  int                m_issue, m_resp, cyc;
  logic [XLEN-1:0]   m_addr;
  logic              m_rw, m_amo;
  logic [4:0]        m_type;
  logic [CLSIZE-1:0] m_wdata, m_rdata;
  int                n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [CLSIZE-1:0] got, input logic [CLSIZE-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [CLSIZE-1:0] rnd_line();
    logic [CLSIZE-1:0] v;
    v = '0;
    for (int i = 0; i < CLSIZE/32; i++) v = {v[CLSIZE-33:0], $urandom()};
    return v;
  endfunction

  task automatic m_reset();
    m_pend = '0; outst = '0; m_rr = '0; m_gnt = '0; m_busy = 0;
    m_issue = -1; m_resp = -1;
    m_addr = '0; m_rw = 0; m_amo = 0; m_type = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic set_req(input logic [IW-1:0] k, input logic [XLEN-1:0] a, input logic rw,
                         input logic amo, input logic [4:0] ty);
    r_addr[k] = a; r_rw[k] = rw; r_amo[k] = amo; r_type[k] = ty; r_data[k] = rnd_line();
  endtask

  // one clock: check this cycle's outputs, drive inputs, advance the model
  task automatic cycle(input logic [N-1:0] s, input logic dn, input logic rs, input logic [CLSIZE-1:0] cd);
    logic [N-1:0]  clr;
    logic [IW-1:0] w, kk;
    bit            found;
    chk("strobe",   core_strobe,   m_busy && cyc == m_issue);
    chk("req_done", req_done,      (m_busy && cyc == m_resp) ? N'(1) << m_gnt : '0);
    chk("core_id",  core_id,       N'(1) << m_gnt);
    chk("addr",     core_addr,     m_addr);
    chk("rw",       core_rw,       m_rw);
    chk("wdata",    core_data,     m_wdata);
    chk("is_amo",   core_is_amo,   m_amo);
    chk("amo_type", core_amo_type, m_type);
    chk("rdata",    req_data,      m_rdata);
    strb = s; cdone = dn; rst = rs; cdata = cd;
    if (rs) m_reset();
    else begin
      clr = '0;
      if (m_busy && cyc == m_resp) begin
        clr = N'(1) << m_gnt;
        outst = outst & ~clr;
        m_rr = (int'(m_gnt) == N-1) ? '0 : IW'(int'(m_gnt) + 1);
        m_busy = 0;
      end else if (m_busy && m_resp < 0 && cyc >= m_issue && dn) begin
        m_resp = cyc + 1;
        m_rdata = cd;
      end else if (!m_busy && m_pend != '0) begin
        found = 0; w = '0;
        for (int i = 0; i < N; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          kk = IW'(i);
`else
          kk = IW'((int'(m_rr) + i) % N);
`endif
          if (!found && m_pend[kk]) begin found = 1; w = kk; end
        end
        m_busy = 1; m_gnt = w; m_issue = cyc + 1; m_resp = -1;
        m_addr = r_addr[w]; m_rw = r_rw[w]; m_wdata = r_data[w]; m_amo = r_amo[w]; m_type = r_type[w];
      end
      m_pend = (m_pend & ~clr) | s;
      outst = outst | s;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic dn);
    for (int i = 0; i < n; i++) cycle('0, dn, 1'b0, rnd_line());
  endtask

  initial begin
    logic [N-1:0]  s;
    logic [IW-1:0] kk;
    logic          rs;
    rst = 1'b1; strb = '0; cdone = 1'b0; cdata = '0;
    r_addr = '0; r_rw = '0; r_amo = '0; r_data = '0; r_type = '0;
    m_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    #1;

    // single read with one wait cycle
    set_req(0, 32'h0000_1040, 1'b0, 1'b0, 5'd0);
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    idle(2, 1'b0);
    cycle('0, 1'b1, 1'b0, {32{8'hAB}});
    idle(3, 1'b0);

    // simultaneous pairs after reset, done in the issue cycle
    cycle('0, 1'b0, 1'b1, rnd_line());
    set_req(0, $urandom(), 1'b1, 1'b0, 5'd0);
    set_req(1, $urandom(), 1'b0, 1'b0, 5'd0);
    cycle(2'b11, 1'b1, 1'b0, rnd_line());
    idle(8, 1'b1);
    set_req(0, $urandom(), 1'b0, 1'b0, 5'd0);
    set_req(1, $urandom(), 1'b1, 1'b0, 5'd0);
    cycle(2'b11, 1'b1, 1'b0, rnd_line());
    idle(8, 1'b1);

    // AMO on req1 held while req0 strobes during its wait
    set_req(1, 32'h0000_2000, 1'b1, 1'b1, 5'b00000);
    cycle(2'b10, 1'b0, 1'b0, rnd_line());
    idle(3, 1'b0);
    set_req(0, $urandom(), 1'b0, 1'b0, 5'd0);
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    idle(3, 1'b0);
    cycle('0, 1'b1, 1'b0, rnd_line());
    idle(8, 1'b1);

    // reset while waiting, then no stale done even with done driven
    set_req(0, $urandom(), 1'b0, 1'b0, 5'd0);
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    idle(3, 1'b0);
    cycle('0, 1'b0, 1'b1, rnd_line());
    idle(6, 1'b1);

    // duplicate strobes before done
    set_req(0, $urandom(), 1'b1, 1'b0, 5'd0);
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    cycle(2'b01, 1'b0, 1'b0, rnd_line());
    cycle('0, 1'b1, 1'b0, rnd_line());
    idle(5, 1'b0);

    // random traffic within the requester contract
    for (int t = 0; t < 1500; t++) begin
      s = '0;
      rs = ($urandom_range(0, 299) == 0);
      if (!rs) begin
        for (int k = 0; k < N; k++) begin
          kk = IW'(k);
          if (!outst[kk]) begin
            if ($urandom_range(0, 99) < 25) begin
              set_req(kk, $urandom(), 1'($urandom()), 1'($urandom()), 5'($urandom()));
              s[kk] = 1'b1;
            end
          end else if (m_pend[kk] && !(m_busy && cyc == m_resp && m_gnt == kk) &&
                       $urandom_range(0, 99) < 10) begin
            s[kk] = 1'b1;
          end
        end
      end
      cycle(s, $urandom_range(0, 99) < 35, rs, rnd_line());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
